// File: rtl/timer_bank.sv
// Bank of independent down-counting timers behind a word-addressed register port.
// Each channel owns CTRL/PRESET/COUNT/STATUS; pending & mask of all channels merge into irq.

module timer_ch #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [1:0]           reg_sel,
    input  logic [CNT_WIDTH-1:0] wdata,
    output logic [31:0]          rdata,
    output logic                 irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COUNT, ST_DONE} state_t;

    state_t               state, state_nxt;
    logic                 en, mode, mask, pending;
    logic [CNT_WIDTH-1:0] preset, count;
    logic                 wr_ctrl, wr_preset, wr_status, halt, expire;

    assign wr_ctrl   = wr && (reg_sel == 2'd0);
    assign wr_preset = wr && (reg_sel == 2'd1);
    assign wr_status = wr && (reg_sel == 2'd3);
    // A CTRL write with en=0 stops the channel at this edge, whatever its state.
    assign halt      = wr_ctrl && !wdata[0];
    // PRESET=0 loads 0 and expires on the first COUNT cycle, same as PRESET=1.
    assign expire    = (state == ST_COUNT) && (count <= CNT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_COUNT;
            ST_COUNT: if (expire) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = mode ? ST_LOAD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (halt) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            mode    <= 1'b0;
            mask    <= 1'b0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            // One-shot completion clears en even against a concurrent en=1 write.
            if (state == ST_DONE && !mode) en <= 1'b0;
            else if (wr_ctrl)              en <= wdata[0];
            if (wr_ctrl) begin
                mode <= wdata[1];
                mask <= wdata[3];
            end
            if (wr_preset) preset <= wdata;

            if (state == ST_LOAD && !halt) count <= preset;
            else if (state == ST_COUNT) begin
                if (expire)     count <= '0;
                else if (!halt) count <= count - CNT_WIDTH'(1);
            end

            // Expiry outranks a same-cycle W1C.
            if (expire)                     pending <= 1'b1;
            else if (wr_status && wdata[0]) pending <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0:    rdata = {28'd0, mask, 1'b0, mode, en};
            2'd1:    rdata = 32'(preset);
            2'd2:    rdata = 32'(count);
            default: rdata = {31'd0, pending};
        endcase
    end

    assign irq = pending && mask;
endmodule

module timer_bank #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 32,
    parameter int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CH_BITS+1:0] addr,
    input  logic               write_enable,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               irq
);
    localparam int SLOTS = 2 ** CH_BITS;

    logic [SLOTS-1:0][31:0] rd_all;
    logic [SLOTS-1:0]       irq_ch;
    logic [CH_BITS-1:0]     ch;
    logic                   unused_wdata;

    assign ch           = addr[CH_BITS+1:2];
    assign unused_wdata = ^write_data;

    // Address slots beyond NUM_CH decode to nothing: reads 0, writes dropped.
    for (genvar c = 0; c < SLOTS; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            timer_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
                .clk     (clk),
                .reset   (reset),
                .wr      (write_enable && (ch == CH_BITS'(c))),
                .reg_sel (addr[1:0]),
                .wdata   (write_data[CNT_WIDTH-1:0]),
                .rdata   (rd_all[c]),
                .irq     (irq_ch[c])
            );
        end else begin : g_off
            assign rd_all[c] = '0;
            assign irq_ch[c] = 1'b0;
        end
    end

    assign read_data = rd_all[ch];
    assign irq       = |irq_ch;
endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: directed checks of the documented timing plus random traffic
// compared against a deadline-based reference model of two 32-bit channels.

module tb_timer_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  addr = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        irq;
    logic [3:0]  addr8 = '0;
    logic        we8 = 1'b0;
    logic [31:0] wd8 = '0;
    logic [31:0] rd8;
    logic        irq8;

    int n_tests = 0;
    int n_fail  = 0;

    timer_bank #(.NUM_CH(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .write_enable(we),
        .write_data(wd), .read_data(rd), .irq(irq)
    );

    timer_bank #(.NUM_CH(3), .CNT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .addr(addr8), .write_enable(we8),
        .write_data(wd8), .read_data(rd8), .irq(irq8)
    );

    always #10 clk = ~clk;

    // Reference model: a run started at edge s loads PRESET at s+2 and expires at
    // s+max(P,1)+2; auto-reload restarts as if re-enabled at the expiry edge.
    longint      cyc = 0;
    bit          m_en[2], m_mode[2], m_mask[2], m_pend[2];
    bit          m_run[2], m_ld[2], m_done[2];
    longint      m_s[2], m_pl[2];
    logic [31:0] m_preset[2], m_held[2];

    function automatic longint clamp0(input longint v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic logic [31:0] m_read(input int c, input int r);
        case (r)
            0: return {28'd0, m_mask[c], 1'b0, m_mode[c], m_en[c]};
            1: return m_preset[c];
            2: return (m_run[c] && m_ld[c]) ? 32'(clamp0(m_pl[c] - (cyc - m_s[c] - 2))) : m_held[c];
            default: return {31'd0, m_pend[c]};
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int c = 0; c < 2; c++) begin
            bit wc, wp, ws, dis, ex, dec, om;
            logic [31:0] op;
            if (reset) begin
                m_en[c] = 0; m_mode[c] = 0; m_mask[c] = 0; m_pend[c] = 0;
                m_run[c] = 0; m_ld[c] = 0; m_done[c] = 0;
                m_preset[c] = '0; m_held[c] = '0;
            end else begin
                wc  = we && (addr[2] == c[0]) && (addr[1:0] == 2'd0);
                wp  = we && (addr[2] == c[0]) && (addr[1:0] == 2'd1);
                ws  = we && (addr[2] == c[0]) && (addr[1:0] == 2'd3);
                dis = wc && !wd[0];
                ex  = m_run[c] && m_ld[c] && (cyc == m_s[c] + ((m_pl[c] < 1) ? 1 : m_pl[c]) + 2);
                dec = m_run[c] && m_done[c];
                om  = m_mode[c];
                op  = m_preset[c];
                if (ex) m_pend[c] = 1;
                else if (ws && wd[0]) m_pend[c] = 0;
                if (dis) begin
                    if (ex) m_held[c] = '0;
                    else if (m_run[c] && m_ld[c])
                        m_held[c] = 32'(clamp0(m_pl[c] - (cyc - m_s[c] - 3)));
                    m_run[c] = 0; m_ld[c] = 0; m_done[c] = 0;
                end else if (ex) begin
                    m_held[c] = '0; m_ld[c] = 0; m_done[c] = 1;
                end else if (dec) begin
                    m_done[c] = 0;
                    if (om) m_s[c] = cyc - 1;
                    else    m_run[c] = 0;
                end else if (m_run[c] && !m_ld[c] && cyc == m_s[c] + 2) begin
                    m_pl[c] = longint'(op); m_ld[c] = 1;
                end else if (!m_run[c] && wc && wd[0]) begin
                    m_run[c] = 1; m_s[c] = cyc; m_ld[c] = 0;
                end
                if (dec && !om) m_en[c] = 0;
                else if (wc)    m_en[c] = wd[0];
                if (wc) begin m_mode[c] = wd[1]; m_mask[c] = wd[3]; end
                if (wp) m_preset[c] = wd;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic wr8(input logic [3:0] a, input logic [31:0] d);
        addr8 = a; wd8 = d; we8 = 1'b1;
        @(posedge clk); #1;
        we8 = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        addr = a; #1;
        chk(tag, rd, exp);
    endtask

    task automatic rd8_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr8 = a; #1;
        chk(tag, rd8, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        for (int a = 0; a < 8; a++) rd_chk($sformatf("rst reg%0d", a), 3'(a), 32'd0);
        chk("rst irq", {31'd0, irq}, 32'd0);
        rd8_chk("rst ch2 preset", 4'b1001, 32'd0);
        rd8_chk("rst ch3 ctrl", 4'b1100, 32'd0);

        // one-shot with mask: irq at t+7, en self-clears, W1C drops irq
        wr(3'b001, 32'd5);
        wr(3'b000, 32'h9);
        idle(6);
        chk("os irq t+6", {31'd0, irq}, 32'd0);
        idle(1);
        chk("os irq t+7", {31'd0, irq}, 32'd1);
        rd_chk("os count", 3'b010, 32'd0);
        idle(1);
        rd_chk("os ctrl", 3'b000, 32'h8);
        chk("os irq hold", {31'd0, irq}, 32'd1);
        wr(3'b011, 32'd1);
        chk("os irq clr", {31'd0, irq}, 32'd0);

        // auto-reload ch1: period 5, W1C at expiry loses
        do_reset();
        wr(3'b101, 32'd3);
        wr(3'b100, 32'hB);
        idle(4);
        rd_chk("ar pend t+4", 3'b111, 32'd0);
        idle(1);
        rd_chk("ar pend t+5", 3'b111, 32'd1);
        wr(3'b111, 32'd1);
        rd_chk("ar w1c", 3'b111, 32'd0);
        idle(3);
        rd_chk("ar pend t+9", 3'b111, 32'd0);
        idle(1);
        rd_chk("ar pend t+10", 3'b111, 32'd1);
        wr(3'b111, 32'd1);
        idle(3);
        rd_chk("ar pend t+14", 3'b111, 32'd0);
        wr(3'b111, 32'd1);
        rd_chk("ar set wins", 3'b111, 32'd1);

        // stop mid-count, then restart reloads PRESET
        do_reset();
        wr(3'b001, 32'd10);
        wr(3'b000, 32'h9);
        idle(6);
        rd_chk("stop pre", 3'b010, 32'd6);
        wr(3'b000, 32'h0);
        rd_chk("stop hold", 3'b010, 32'd6);
        idle(5);
        rd_chk("stop hold2", 3'b010, 32'd6);
        rd_chk("stop pend", 3'b011, 32'd0);
        chk("stop irq", {31'd0, irq}, 32'd0);
        wr(3'b000, 32'h9);
        idle(2);
        rd_chk("restart load", 3'b010, 32'd10);
        idle(9);
        chk("restart irq t+11", {31'd0, irq}, 32'd0);
        idle(1);
        chk("restart irq t+12", {31'd0, irq}, 32'd1);

        // unmasked: pending sets, irq only after mask
        do_reset();
        wr(3'b001, 32'd2);
        wr(3'b000, 32'h1);
        idle(3);
        rd_chk("nm pend t+3", 3'b011, 32'd0);
        idle(1);
        rd_chk("nm pend t+4", 3'b011, 32'd1);
        chk("nm irq", {31'd0, irq}, 32'd0);
        idle(2);
        wr(3'b000, 32'h8);
        chk("nm irq mask", {31'd0, irq}, 32'd1);

        // narrow counter, absent channel, reset while counting
        do_reset();
        wr8(4'b0001, 32'h1FF);
        rd8_chk("w8 trunc", 4'b0001, 32'hFF);
        wr8(4'b1001, 32'h33);
        rd8_chk("w8 ch2", 4'b1001, 32'h33);
        wr8(4'b1101, 32'h55);
        rd8_chk("w8 ch3", 4'b1101, 32'd0);
        wr8(4'b0000, 32'h9);
        wr(3'b001, 32'd10);
        wr(3'b000, 32'h9);
        idle(5);
        do_reset();
        for (int a = 0; a < 8; a++) rd_chk($sformatf("mid rst reg%0d", a), 3'(a), 32'd0);
        rd8_chk("mid rst w8 preset", 4'b0001, 32'd0);
        rd8_chk("mid rst w8 ctrl", 4'b0000, 32'd0);
        idle(20);
        chk("mid rst irq", {31'd0, irq}, 32'd0);
        chk("mid rst irq8", {31'd0, irq8}, 32'd0);
        rd_chk("mid rst pend", 3'b011, 32'd0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else if ($urandom_range(0, 9) < 4) begin
                logic [2:0]  a;
                logic [31:0] d;
                a = 3'($urandom_range(0, 7));
                d = $urandom;
                case (a[1:0])
                    2'd0: d[0] = ($urandom_range(0, 9) < 7);
                    2'd1: d = $urandom_range(0, 7);
                    default: ;
                endcase
                wr(a, d);
            end else idle(1);
            for (int a = 0; a < 8; a++)
                rd_chk($sformatf("rnd %0d ch%0d r%0d", i, a / 4, a % 4), 3'(a), m_read(a / 4, a % 4));
            chk($sformatf("rnd %0d irq", i), {31'd0, irq},
                {31'd0, (m_pend[0] & m_mask[0]) | (m_pend[1] & m_mask[1])});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
